// File: rtl/branch_predict_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, opcode/funct3 constants and branch evaluation
//               for the Decode/Execute branch prediction control.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_PRED   = 2'b01,
        PC_REC_NT = 2'b10,
        PC_REC_T  = 2'b11
    } pcsrc_t;

    typedef enum logic {
        CTR_DEC = 1'b0,
        CTR_INC = 1'b1
    } ctr_cmd_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Returns {supported, taken}; unsupported encodings resolve as not taken.
    function automatic logic [1:0] branch_eval(
        input logic [2:0] funct3,
        input logic       n,
        input logic       z,
        input logic       c
    );
        logic [1:0] w_res;
        w_res = 2'b00;
        case (funct3)
            F3_BEQ:  w_res = {1'b1, z};
            F3_BNE:  w_res = {1'b1, ~z};
            F3_BLT:  w_res = {1'b1, n};
            F3_BGE:  w_res = {1'b1, ~n};
            F3_BLTU: w_res = {1'b1, ~c};
            F3_BGEU: w_res = {1'b1, c};
            default: w_res = 2'b00;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_ctrl_table.sv
`default_nettype none
// ============================================================================
// Module      : sat_ctr_table
// Description : PC-indexed table of saturating counters, one combinational
//               read port and one inc/dec write port.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_ctr_table
    import bp_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx,
    output logic [CTR_BITS-1:0]            rd_ctr,
    input  logic                           wr_en,
    input  logic [$clog2(BHT_ENTRIES)-1:0] wr_idx,
    input  ctr_cmd_t                       wr_cmd
);

    localparam logic [CTR_BITS-1:0] c_ctr_max  = '1;
    // Only the MSB set: weakly taken, and still valid for 1-bit counters.
    localparam logic [CTR_BITS-1:0] c_ctr_weak = c_ctr_max ^ (c_ctr_max >> 1);

    logic [CTR_BITS-1:0] r_ctr [BHT_ENTRIES];
    logic [CTR_BITS-1:0] w_cur;
    logic [CTR_BITS-1:0] w_next;
    logic                w_sat;

    assign rd_ctr = r_ctr[rd_idx];

    always_comb begin
        w_cur  = r_ctr[wr_idx];
        w_sat  = 1'b0;
        w_next = w_cur;
        if (wr_cmd == CTR_INC) begin
            w_sat  = (w_cur == c_ctr_max);
            w_next = w_cur + 1'b1;
        end else begin
            w_sat  = (w_cur == '0);
            w_next = w_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_ctr[i] <= c_ctr_weak;
            end
        end else if (wr_en && !w_sat) begin
            r_ctr[wr_idx] <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl
// Description : Decode-stage branch/jump control with counter-table
//               prediction, Execute resolution, recovery and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int STAT_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_D,
    input  logic                 flush_D,
    input  logic [6:0]           op_D,
    input  logic [XLEN-1:0]      pc_D,
    input  logic                 branch_E,
    input  logic [2:0]           funct3_E,
    input  logic                 N,
    input  logic                 Z,
    input  logic                 C,
    output logic                 branch_D,
    output logic                 jump_D,
    output logic                 pred_taken_D,
    output logic [1:0]           PCSrcD,
    output logic                 mispredict_E,
    output logic                 bad_branch_E,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int c_idx_w = $clog2(BHT_ENTRIES);

    logic [c_idx_w-1:0]   w_idx_D;
    logic [c_idx_w-1:0]   r_idx_E;
    logic [CTR_BITS-1:0]  w_ctr_D;
    logic                 r_pred_taken_E;
    logic                 w_supported_E;
    logic                 w_outcome_E;
    ctr_cmd_t             w_cmd_E;
    pcsrc_t               w_pcsrc;
    logic [STAT_BITS-1:0] r_branch_count;
    logic [STAT_BITS-1:0] r_mispredict_count;
    logic                 w_unused_pc;

    assign branch_D = (op_D == OP_BRANCH);
    assign jump_D   = (op_D == OP_JAL) || (op_D == OP_JALR);
    assign w_idx_D  = pc_D[c_idx_w+1:2];
    // PC bits outside the index field carry no prediction information.
    assign w_unused_pc = ^{pc_D[XLEN-1:c_idx_w+2], pc_D[1:0]};

    sat_ctr_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_BITS    (CTR_BITS)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (w_idx_D),
        .rd_ctr (w_ctr_D),
        .wr_en  (branch_E),
        .wr_idx (r_idx_E),
        .wr_cmd (w_cmd_E)
    );

    assign pred_taken_D = branch_D & w_ctr_D[CTR_BITS-1];

    always_comb begin
        {w_supported_E, w_outcome_E} = branch_eval(funct3_E, N, Z, C);
        w_cmd_E = w_outcome_E ? CTR_INC : CTR_DEC;
    end

    assign bad_branch_E = branch_E & ~w_supported_E;
    assign mispredict_E = branch_E & (w_outcome_E != r_pred_taken_E);

    // Recovery from Execute outranks anything Decode wants to do.
    always_comb begin
        w_pcsrc = PC_INC;
        if (mispredict_E) begin
            w_pcsrc = w_outcome_E ? PC_REC_T : PC_REC_NT;
        end else if (jump_D || pred_taken_D) begin
            w_pcsrc = PC_PRED;
        end
    end

    assign PCSrcD = w_pcsrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_taken_E <= 1'b0;
            r_idx_E        <= '0;
        end else if (flush_D || mispredict_E) begin
            r_pred_taken_E <= 1'b0;
            r_idx_E        <= '0;
        end else if (!stall_D) begin
            r_pred_taken_E <= pred_taken_D;
            r_idx_E        <= w_idx_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (branch_E && !(&r_branch_count)) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if (mispredict_E && !(&r_mispredict_count)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_ctrl
// Description : Directed self-checking bench with a behavioural predictor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    localparam int XLEN     = 32;
    localparam int BHT      = 64;
    localparam int CB       = 2;
    localparam int SB       = 4;
    localparam int CTR_MAX  = (1 << CB) - 1;
    localparam int CTR_THR  = 1 << (CB - 1);
    localparam int STAT_MAX = (1 << SB) - 1;

    localparam logic [6:0] OPB    = 7'h63;
    localparam logic [6:0] OPJAL  = 7'h6f;
    localparam logic [6:0] OPJALR = 7'h67;
    localparam logic [6:0] OPNOP  = 7'h13;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            stall_D  = 1'b0;
    logic            flush_D  = 1'b0;
    logic [6:0]      op_D     = OPNOP;
    logic [XLEN-1:0] pc_D     = '0;
    logic            branch_E = 1'b0;
    logic [2:0]      funct3_E = 3'b000;
    logic            N = 1'b0, Z = 1'b0, C = 1'b0;

    logic            branch_D, jump_D, pred_taken_D, mispredict_E, bad_branch_E;
    logic [1:0]      PCSrcD;
    logic [SB-1:0]   branch_count, mispredict_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(
        .XLEN(XLEN), .BHT_ENTRIES(BHT), .CTR_BITS(CB), .STAT_BITS(SB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_D(stall_D), .flush_D(flush_D),
        .op_D(op_D), .pc_D(pc_D), .branch_E(branch_E), .funct3_E(funct3_E),
        .N(N), .Z(Z), .C(C),
        .branch_D(branch_D), .jump_D(jump_D), .pred_taken_D(pred_taken_D),
        .PCSrcD(PCSrcD), .mispredict_E(mispredict_E), .bad_branch_E(bad_branch_E),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ctr [BHT];
    bit m_pred_E;
    int m_idx_E;
    int m_bc, m_mc;
    bit e_branch, e_jump, e_pred, e_tk, e_bad, e_mis;
    int e_pcsrc;

    function automatic void model_reset();
        for (int i = 0; i < BHT; i++) m_ctr[i] = CTR_THR;
        m_pred_E = 1'b0;
        m_idx_E  = 0;
        m_bc     = 0;
        m_mc     = 0;
    endfunction

    function automatic void model_comb();
        int idx;
        idx      = int'((pc_D >> 2) % BHT);
        e_branch = (op_D == OPB);
        e_jump   = (op_D == OPJAL) || (op_D == OPJALR);
        e_pred   = e_branch && (m_ctr[idx] >= CTR_THR);
        e_bad    = 1'b0;
        case (funct3_E)
            3'd0: e_tk = Z;
            3'd1: e_tk = !Z;
            3'd4: e_tk = N;
            3'd5: e_tk = !N;
            3'd6: e_tk = !C;
            3'd7: e_tk = C;
            default: begin e_tk = 1'b0; e_bad = 1'b1; end
        endcase
        e_bad = e_bad && branch_E;
        e_mis = branch_E && (e_tk != m_pred_E);
        if (e_mis)                          e_pcsrc = e_tk ? 3 : 2;
        else if (e_jump || e_pred)          e_pcsrc = 1;
        else                                e_pcsrc = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_comb();
            if (branch_E) begin
                if (e_tk) m_ctr[m_idx_E] = (m_ctr[m_idx_E] < CTR_MAX) ? m_ctr[m_idx_E] + 1 : CTR_MAX;
                else      m_ctr[m_idx_E] = (m_ctr[m_idx_E] > 0) ? m_ctr[m_idx_E] - 1 : 0;
                m_bc = (m_bc < STAT_MAX) ? m_bc + 1 : STAT_MAX;
                if (e_mis) m_mc = (m_mc < STAT_MAX) ? m_mc + 1 : STAT_MAX;
            end
            if (flush_D || e_mis) begin
                m_pred_E = 1'b0;
                m_idx_E  = 0;
            end else if (!stall_D) begin
                m_pred_E = e_pred;
                m_idx_E  = int'((pc_D >> 2) % BHT);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            model_comb();
            check("model_branch_D",         {31'd0, branch_D},     {31'd0, e_branch});
            check("model_jump_D",           {31'd0, jump_D},       {31'd0, e_jump});
            check("model_pred_taken_D",     {31'd0, pred_taken_D}, {31'd0, e_pred});
            check("model_PCSrcD",           {30'd0, PCSrcD},       e_pcsrc);
            check("model_mispredict_E",     {31'd0, mispredict_E}, {31'd0, e_mis});
            check("model_bad_branch_E",     {31'd0, bad_branch_E}, {31'd0, e_bad});
            check("model_branch_count",     {28'd0, branch_count},     m_bc);
            check("model_mispredict_count", {28'd0, mispredict_count}, m_mc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [6:0] op, input logic [31:0] pc, input logic be,
                       input logic [2:0] f3, input logic n, input logic z, input logic c,
                       input logic st, input logic fl);
        @(posedge clk);
        #1;
        op_D = op; pc_D = pc; branch_E = be; funct3_E = f3;
        N = n; Z = z; C = c; stall_D = st; flush_D = fl;
        @(negedge clk);
    endtask

    task automatic dbr(input logic [31:0] pc);
        cyc(OPB, pc, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ebr(input logic [2:0] f3, input logic n, input logic z, input logic c);
        cyc(OPNOP, 32'h0, 1'b1, f3, n, z, c, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("lit_reset_branch_count", {28'd0, branch_count}, 0);
        check("lit_reset_mispredict_count", {28'd0, mispredict_count}, 0);
        check("lit_reset_PCSrcD", {30'd0, PCSrcD}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // First BEQ at 0x40 predicts taken, resolves not taken.
        dbr(32'h40);
        check("lit_first_pred", {31'd0, pred_taken_D}, 1);
        check("lit_first_pcsrc", {30'd0, PCSrcD}, 1);
        ebr(3'd0, 1'b0, 1'b0, 1'b0);
        check("lit_first_mis", {31'd0, mispredict_E}, 1);
        check("lit_first_rec_nt", {30'd0, PCSrcD}, 2);
        cyc(OPNOP, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_mc_one", {28'd0, mispredict_count}, 1);
        check("lit_bc_one", {28'd0, branch_count}, 1);

        // Train down to zero, then a taken outcome recovers to target.
        dbr(32'h40);
        check("lit_weak_nt_pcsrc", {30'd0, PCSrcD}, 0);
        ebr(3'd0, 1'b0, 1'b0, 1'b0);
        check("lit_nt_no_mis", {31'd0, mispredict_E}, 0);
        dbr(32'h40);
        ebr(3'd0, 1'b0, 1'b0, 1'b0);
        dbr(32'h40);
        check("lit_strong_nt_pcsrc", {30'd0, PCSrcD}, 0);
        ebr(3'd0, 1'b0, 1'b1, 1'b0);
        check("lit_rec_t", {30'd0, PCSrcD}, 3);
        dbr(32'h40);
        check("lit_ctr01_pred", {31'd0, pred_taken_D}, 0);

        cyc(OPJAL, 32'h44, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_jal_pcsrc", {30'd0, PCSrcD}, 1);
        cyc(OPJALR, 32'h48, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_jalr_jump", {31'd0, jump_D}, 1);

        // Unsigned compares agreeing with a taken prediction; counter saturates.
        dbr(32'h80);
        ebr(3'd6, 1'b0, 1'b0, 1'b0);
        check("lit_bltu_no_mis", {31'd0, mispredict_E}, 0);
        dbr(32'h80);
        ebr(3'd7, 1'b0, 1'b0, 1'b1);
        check("lit_bgeu_no_mis", {31'd0, mispredict_E}, 0);
        dbr(32'h80);
        check("lit_sat_pred", {31'd0, pred_taken_D}, 1);

        // Unsupported funct3 resolves not taken.
        ebr(3'd3, 1'b1, 1'b1, 1'b1);
        check("lit_bad3_flag", {31'd0, bad_branch_E}, 1);
        check("lit_bad3_rec", {30'd0, PCSrcD}, 2);
        ebr(3'd2, 1'b1, 1'b1, 1'b1);
        check("lit_bad2_flag", {31'd0, bad_branch_E}, 1);
        check("lit_bad2_no_mis", {31'd0, mispredict_E}, 0);

        // Same-index read during write sees the old counter.
        dbr(32'hC0);
        cyc(OPB, 32'hC0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_same_idx_old", {31'd0, pred_taken_D}, 1);
        check("lit_same_idx_rec", {30'd0, PCSrcD}, 2);
        dbr(32'hC0);
        check("lit_same_idx_new", {31'd0, pred_taken_D}, 0);

        // Stall holds the prediction register for three cycles.
        dbr(32'h80);
        for (int i = 0; i < 3; i++) cyc(OPNOP, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ebr(3'd0, 1'b0, 1'b1, 1'b0);
        check("lit_stall_hold", {31'd0, mispredict_E}, 0);

        // Flush beats stall.
        dbr(32'h80);
        cyc(OPNOP, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        ebr(3'd0, 1'b0, 1'b1, 1'b0);
        check("lit_flush_mis", {31'd0, mispredict_E}, 1);
        check("lit_flush_rec_t", {30'd0, PCSrcD}, 3);

        // Statistics saturation.
        for (int i = 0; i < 20; i++) ebr(3'd0, 1'b0, 1'b1, 1'b0);
        cyc(OPNOP, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_mc_sat", {28'd0, mispredict_count}, 15);
        check("lit_bc_sat", {28'd0, branch_count}, 15);

        // Asynchronous reset with a taken prediction in flight.
        dbr(32'h80);
        @(posedge clk);
        #1;
        op_D = OPNOP; pc_D = '0; branch_E = 1'b1; funct3_E = 3'd0; Z = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("lit_rst_mis", {31'd0, mispredict_E}, 0);
        check("lit_rst_bc", {28'd0, branch_count}, 0);
        check("lit_rst_mc", {28'd0, mispredict_count}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        branch_E = 1'b0;
        dbr(32'h80);
        check("lit_post_rst_pred", {31'd0, pred_taken_D}, 1);
        ebr(3'd0, 1'b0, 1'b0, 1'b0);
        dbr(32'h80);
        check("lit_post_rst_weak", {31'd0, pred_taken_D}, 0);
        check("lit_post_rst_mc", {28'd0, mispredict_count}, 1);
        dbr(32'h40);
        check("lit_post_rst_idx16", {31'd0, pred_taken_D}, 1);

        cyc(OPNOP, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Parametrised successor to the Decode-stage branch/jump control. It replaces the fixed "always predict taken" policy with a PC-indexed table of saturating counters. It carries each prediction into Execute, resolves the condition there (including unsigned compares), and raises a redirect on a misprediction. It also trains the table and keeps saturating branch/mispredict statistics. It sits between the Decode opcode field and the fetch PC mux, and drives PCSrcD.

## Interface
Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 64, counter-table depth; power of two, ≥ 2.
- CTR_BITS, 2, counter width; ≥ 1.
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall_D  in  1  holds the D→E prediction register.
- flush_D  in  1  clears the D→E prediction register (bubble).
- op_D  in  7  Decode opcode.
- pc_D  in  XLEN  Decode PC.
- branch_E  in  1  Execute holds a valid B-type instruction.
- funct3_E  in  3  Execute branch type.
- N, Z, C  in  1 each  ALU flags from the Execute compare; C=1 means no borrow.
- branch_D, jump_D  out  1 each  opcode 1100011 / opcode 1101111 or 1100111.
- pred_taken_D  out  1  MSB of the indexed counter, gated by branch_D.
- PCSrcD  out  2  00 = PC+4, 01 = predicted target, 10 = recover to branch PC+4, 11 = recover to branch target.
- mispredict_E  out  1  Execute branch outcome differs from its prediction.
- bad_branch_E  out  1  funct3_E is not a supported branch type.
- branch_count, mispredict_count  out  STAT_BITS each  saturating statistics.

## Operation
- Index: idx = pc_D[$clog2(BHT_ENTRIES)+1:2].
- Counter reset value: 1 followed by CTR_BITS-1 zeros (weakly taken).
- D→E register holds pred_taken_E and idx_E.
  - Loads {pred_taken_D & branch_D, idx} when !stall_D.
  - Clears to 0 on flush_D or mispredict_E.
- Outcome in Execute, by funct3_E:
  - 000 BEQ = Z.
  - 001 BNE = !Z.
  - 100 BLT = N.
  - 101 BGE = !N.
  - 110 BLTU = !C.
  - 111 BGEU = C.
  - 010 / 011: outcome = 0 and bad_branch_E = 1 (while branch_E).
- mispredict_E = branch_E & (outcome != pred_taken_E).
- PCSrcD priority:
  1. mispredict_E: 11 if outcome = 1, else 10.
  2. jump_D, or branch_D & pred_taken_D: 01.
  3. Otherwise: 00.
- Counter training:
  - Happens when branch_E is 1.
  - Entry idx_E increments on a taken outcome, decrements on not taken.
  - Saturates at all-ones and at zero.
- Statistics:
  - branch_count increments per resolved branch (branch_E).
  - mispredict_count increments per mispredict_E.
  - Both hold at all-ones (no wrap).
- Same-cycle D read and E write to the same index: D sees the pre-update value (no bypass).
- Reset mid-operation: everything returns to reset values immediately. Any in-flight prediction is discarded and no training happens for it.

## Timing
- branch_D, jump_D, pred_taken_D, PCSrcD, mispredict_E and bad_branch_E are combinational, valid the same cycle as their inputs.
- A counter update is visible to a D read on the cycle after branch_E.
- The D→E register has 1-cycle latency. The branch resolves in the cycle after its D cycle, unless stall_D holds it.
- Reset values:
  - All counters weakly taken.
  - pred_taken_E = 0, idx_E = 0.
  - Statistics = 0.
  - Combinational outputs follow their inputs.
- Stall and flush both active: flush wins.
- mispredict_E together with branch_D: recovery wins, and the D prediction is dropped.

## Structure
- Shared package bp_pkg:
  - pcsrc_t enum (PC_INC, PC_PRED, PC_REC_NT, PC_REC_T).
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 constants for the six branch types.
- Sub-module sat_ctr_table (parameters BHT_ENTRIES, CTR_BITS):
  - One combinational read port.
  - One write port carrying an inc/dec command.
  - Asynchronous reset to weakly taken.

## Test plan
- Reset, then BEQ at pc_D=0x40: pred_taken_D=1 and PCSrcD=01. Next cycle Z=0 → mispredict_E=1, PCSrcD=10, counter[16]=01, mispredict_count=1.
- Train counter[16] down twice to 00, then BEQ at 0x40 again: PCSrcD=00. With Z=1 in E → PCSrcD=11 and counter=01.
- BLTU with C=0 and BGEU with C=1 after a taken prediction: no mispredict, counter saturates at 11 after repeats.
- funct3_E=010 with branch_E=1: bad_branch_E=1, outcome not taken.
- Same-index read/write in one cycle: D sees the old value. stall_D held 3 cycles: pred register unchanged. stall_D+flush_D: register cleared.
- STAT_BITS=4: 20 mispredicts → mispredict_count=15 (saturated). rst_n pulled low mid-stream: all counters weakly taken, statistics 0.
